dmem_resp: RTL and testbench

Data-memory responder for the pipelined datapath: the memory-side end of the Memory-stage interface that the datapath drives with its ALU result as address, its store data, and its load-data input. Accepts one load or store at a time, models a configurable number of wait states, and returns a registered read word plus a one-cycle ready pulse that the hazard logic uses to stall the pipeline. Holds a word-addressed RAM array and flags out-of-range accesses.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 23 ++
 rtl/dmem_resp.sv | 132 +++++++++++++
 tb/tb_dmem_resp.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the FSM state encoding, the wait counter width and the default geometry.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W           = 4;
    localparam int DEFAULT_DEPTH   = 64;
    localparam int DEFAULT_LATENCY = 2;

    // True when a 30-bit word address falls outside an array of the given depth.
    function automatic logic is_out_of_range(input logic [29:0] word_addr, input int depth);
        return word_addr >= 30'(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage for the data memory: synchronous write, combinational read.
// Contents are deliberately left untouched by reset.
module dmem_array #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_resp.sv
// Memory-stage data-memory responder: accepts one access at a time, waits LATENCY
// cycles, commits the access and returns a registered word with a one-cycle ready pulse.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemReadyM,
    output logic        MemErrM,
    output logic        BusyM
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] cap_idx;
    logic             cap_write;
    logic [31:0]      cap_wdata;
    logic             cap_oor;

    logic [IDX_W-1:0] req_idx;
    logic             req_oor;
    logic             unused_byte_offset;

    logic             commit;
    logic [IDX_W-1:0] commit_idx;
    logic             commit_write;
    logic [31:0]      commit_wdata;
    logic             commit_oor;

    logic             array_we;
    logic [31:0]      array_rdata;

    assign req_idx            = AddrM[IDX_W+1:2];
    assign req_oor            = is_out_of_range(AddrM[31:2], DEPTH);
    assign unused_byte_offset = ^AddrM[1:0];

    // With zero wait states the access commits on the acceptance edge itself, so the
    // commit path must see the live request rather than the not-yet-captured copy.
    always_comb begin
        commit       = 1'b0;
        commit_idx   = cap_idx;
        commit_write = cap_write;
        commit_wdata = cap_wdata;
        commit_oor   = cap_oor;
        if (state == IDLE && MemReqM && LATENCY == 0) begin
            commit       = 1'b1;
            commit_idx   = req_idx;
            commit_write = MemWriteM;
            commit_wdata = WriteDataM;
            commit_oor   = req_oor;
        end else if (state == WAIT && cnt == CNT_W'(1)) begin
            commit = 1'b1;
        end
    end

    assign array_we = commit && commit_write && !commit_oor && !reset;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (array_we),
        .addr  (commit_idx),
        .wdata (commit_wdata),
        .rdata (array_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_idx   <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
            cap_oor   <= 1'b0;
            ReadDataM <= '0;
            MemReadyM <= 1'b0;
            MemErrM   <= 1'b0;
            BusyM     <= 1'b0;
        end else begin
            MemReadyM <= 1'b0;
            MemErrM   <= 1'b0;
            if (commit) begin
                MemReadyM <= 1'b1;
                MemErrM   <= commit_oor;
                if (!commit_write) begin
                    ReadDataM <= commit_oor ? 32'h0 : array_rdata;
                end
            end

            case (state)
                IDLE: begin
                    if (MemReqM) begin
                        cap_idx   <= req_idx;
                        cap_write <= MemWriteM;
                        cap_wdata <= WriteDataM;
                        cap_oor   <= req_oor;
                        cnt       <= CNT_W'(LATENCY);
                        state     <= (LATENCY > 0) ? WAIT : DONE;
                        BusyM     <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                // A request still high here is the completed one being held; ignore it.
                DONE: begin
                    state <= IDLE;
                    BusyM <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BusyM <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: one instance with LATENCY=2 and one with LATENCY=0,
// driven from tables of directed accesses plus hand-written held-request and reset sequences.
module tb_dmem_resp;

    logic clk = 1'b0;
    logic reset;

    logic        req2, wr2, rdy2, err2, busy2;
    logic [31:0] addr2, wd2, rd2;
    logic        req0, wr0, rdy0, err0, busy0;
    logic [31:0] addr0, wd0, rd0;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t t2[10];
    vec_t t0[5];

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH(64), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset), .MemReqM(req2), .MemWriteM(wr2), .AddrM(addr2),
        .WriteDataM(wd2), .ReadDataM(rd2), .MemReadyM(rdy2), .MemErrM(err2), .BusyM(busy2)
    );

    dmem_resp #(.DEPTH(64), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset(reset), .MemReqM(req0), .MemWriteM(wr0), .AddrM(addr0),
        .WriteDataM(wd0), .ReadDataM(rd0), .MemReadyM(rdy0), .MemErrM(err0), .BusyM(busy0)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input bit req, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (sel == 2) begin
            req2 = req; wr2 = wr; addr2 = a; wd2 = d;
        end else begin
            req0 = req; wr0 = wr; addr0 = a; wd0 = d;
        end
    endtask

    // Issue one access, wait (bounded) for the ready pulse and check everything seen with it.
    task automatic applyStimulus(input int sel, input vec_t v, input int exp_lat, input bit keep_req, input string tag);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        drive(sel, 1'b1, v.write, v.addr, v.wdata);
        while (!seen && n < 20) begin
            tick();
            n++;
            seen = (sel == 2) ? rdy2 : rdy0;
        end
        checkOutput({tag, " latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_lat));
        checkOutput({tag, " err"},   32'((sel == 2) ? err2 : err0), 32'(v.exp_err));
        checkOutput({tag, " rdata"}, (sel == 2) ? rd2 : rd0, v.exp_rdata);
        checkOutput({tag, " busy"},  32'((sel == 2) ? busy2 : busy0), 32'd1);
        if (!keep_req) begin
            drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
            tick();
            checkOutput({tag, " ready drop"}, 32'((sel == 2) ? rdy2 : rdy0), 32'd0);
            checkOutput({tag, " busy drop"},  32'((sel == 2) ? busy2 : busy0), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ready_at[$];

        t2[0] = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
        t2[1] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        t2[2] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        t2[3] = '{1'b1, 32'h0000_0100, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1};
        t2[4] = '{1'b0, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1};
        t2[5] = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0};
        t2[6] = '{1'b1, 32'h0000_00FC, 32'h0BAD_F00D, 32'hA5A5_A5A5, 1'b0};
        t2[7] = '{1'b0, 32'h0000_00FC, 32'h0,         32'h0BAD_F00D, 1'b0};
        t2[8] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b1};
        t2[9] = '{1'b1, 32'h0000_0008, 32'h1111_2222, 32'h0000_0000, 1'b0};

        t0[0] = '{1'b1, 32'h0000_0000, 32'h0102_0304, 32'h0000_0000, 1'b0};
        t0[1] = '{1'b1, 32'h0000_0004, 32'h5566_7788, 32'h0000_0000, 1'b0};
        t0[2] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0102_0304, 1'b0};
        t0[3] = '{1'b0, 32'h0000_0004, 32'h0,         32'h5566_7788, 1'b0};
        t0[4] = '{1'b0, 32'h0000_0006, 32'h0,         32'h5566_7788, 1'b0};

        reset = 1'b1;
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) tick();
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("idle[%0d] rdata", i), rd2, 32'h0);
            checkOutput($sformatf("idle[%0d] ready", i), 32'(rdy2), 32'd0);
            checkOutput($sformatf("idle[%0d] err", i),   32'(err2), 32'd0);
            checkOutput($sformatf("idle[%0d] busy", i),  32'(busy2), 32'd0);
        end

        for (int i = 0; i < 10; i++) begin
            applyStimulus(2, t2[i], 3, 1'b0, $sformatf("lat2[%0d]", i));
        end

        // Held request: exactly one completion every LATENCY+2 = 4 cycles.
        drive(2, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (rdy2) begin
                ready_at.push_back(c);
                checkOutput($sformatf("held ready@%0d rdata", c), rd2, 32'hDEAD_BEEF);
            end
        end
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("held completions", 32'(ready_at.size()), 32'd3);
        if (ready_at.size() == 3) begin
            checkOutput("held first", 32'(ready_at[0]), 32'd3);
            checkOutput("held gap1", 32'(ready_at[1] - ready_at[0]), 32'd4);
            checkOutput("held gap2", 32'(ready_at[2] - ready_at[1]), 32'd4);
        end
        tick();

        // Reset while a store waits: no completion and no write.
        drive(2, 1'b1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D);
        tick();
        checkOutput("rst busy before", 32'(busy2), 32'd1);
        tick();
        reset = 1'b1;
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("rst busy", 32'(busy2), 32'd0);
        checkOutput("rst ready", 32'(rdy2), 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput($sformatf("rst quiet[%0d]", c), 32'(rdy2), 32'd0);
        end
        applyStimulus(2, '{1'b0, 32'h0000_0008, 32'h0, 32'h1111_2222, 1'b0}, 3, 1'b0, "rst reload");

        // Zero wait states, back-to-back: first ready after 1 cycle, then one per 2 cycles.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, t0[i], (i == 0) ? 1 : 2, (i != 4), $sformatf("lat0[%0d]", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
